// File: rtl/knn_topk_core.sv
// k-nearest-neighbour engine: streamed squared distance plus sorted top-K list.
// Optional majority vote output enabled by defining KNN_VOTE_EN.
module knn_topk_core #(
  parameter int DATA_W  = 16,
  parameter int DIM     = 2,
  parameter int K       = 4,
  parameter int LABEL_W = 8,
  localparam int DIST_W = 2*DATA_W+1+$clog2(DIM)+((DIM==1)?1:0),
  localparam int IDX_W  = (K > 1) ? $clog2(K) : 1,
  localparam int CNT_W  = $clog2(K+1)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  clear,
  input  logic [DIM*DATA_W-1:0] test_pt,
  input  logic                  tr_valid,
  output logic                  tr_ready,
  input  logic [DIM*DATA_W-1:0] tr_pt,
  input  logic [LABEL_W-1:0]    tr_label,
  output logic                  busy,
  output logic [CNT_W-1:0]      count,
  input  logic [IDX_W-1:0]      rd_idx,
  output logic                  rd_valid,
  output logic [DIST_W-1:0]     rd_dist,
  output logic [LABEL_W-1:0]    rd_label
`ifdef KNN_VOTE_EN
  ,
  output logic [LABEL_W-1:0]    vote_label
`endif
);

  localparam int DC_W = (DIM > 1) ? $clog2(DIM) : 1;
  localparam int SQ_W = 2*DATA_W+2;

  typedef enum logic [1:0] {
    IDLE,
    DIST,
    INSERT
  } state_t;

  state_t state;

  logic [DC_W-1:0]       dcnt;
  logic [DIST_W-1:0]     acc;
  logic [DIM*DATA_W-1:0] test_q;
  logic [DIM*DATA_W-1:0] pt_q;
  logic [LABEL_W-1:0]    lab_q;
  logic [CNT_W-1:0]      cnt;

  logic               vld [K];
  logic [DIST_W-1:0]  dst [K];
  logic [LABEL_W-1:0] lab [K];

  logic               n_vld [K];
  logic [DIST_W-1:0]  n_dst [K];
  logic [LABEL_W-1:0] n_lab [K];

  logic [DATA_W-1:0]        a_d;
  logic [DATA_W-1:0]        b_d;
  logic signed [DATA_W:0]   diff;
  logic signed [SQ_W-1:0]   sq;
  logic [DIST_W-1:0]        sq_ext;
  logic [CNT_W-1:0]         pos;
  logic                     ins_ok;

  assign tr_ready = (state == IDLE) & ~clear;
  assign busy     = (state != IDLE);
  assign count    = cnt;

  always_comb begin
    a_d    = pt_q[int'(dcnt)*DATA_W +: DATA_W];
    b_d    = test_q[int'(dcnt)*DATA_W +: DATA_W];
    diff   = $signed({a_d[DATA_W-1], a_d}) - $signed({b_d[DATA_W-1], b_d});
    sq     = diff * diff;
    sq_ext = DIST_W'($unsigned(sq));
  end

  // Valid entries form a sorted prefix; ties place the new entry after older ones.
  always_comb begin
    pos = '0;
    for (int i = 0; i < K; i++) begin
      if (vld[i] && (dst[i] <= acc)) pos = pos + CNT_W'(1);
    end
    ins_ok = (int'(pos) < K);
    for (int i = 0; i < K; i++) begin
      n_vld[i] = vld[i];
      n_dst[i] = dst[i];
      n_lab[i] = lab[i];
      if (i == int'(pos)) begin
        n_vld[i] = 1'b1;
        n_dst[i] = acc;
        n_lab[i] = lab_q;
      end else if ((i > int'(pos)) && (i > 0)) begin
        n_vld[i] = vld[i-1];
        n_dst[i] = dst[i-1];
        n_lab[i] = lab[i-1];
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state  <= IDLE;
      dcnt   <= '0;
      acc    <= '0;
      test_q <= '0;
      pt_q   <= '0;
      lab_q  <= '0;
      cnt    <= '0;
      for (int i = 0; i < K; i++) begin
        vld[i] <= 1'b0;
        dst[i] <= '1;
        lab[i] <= '0;
      end
    end else if (clear) begin
      state <= IDLE;
      dcnt  <= '0;
      acc   <= '0;
      cnt   <= '0;
      for (int i = 0; i < K; i++) begin
        vld[i] <= 1'b0;
        dst[i] <= '1;
        lab[i] <= '0;
      end
    end else begin
      unique case (state)
        IDLE: begin
          if (tr_valid) begin
            test_q <= test_pt;
            pt_q   <= tr_pt;
            lab_q  <= tr_label;
            dcnt   <= '0;
            acc    <= '0;
            state  <= DIST;
          end
        end
        DIST: begin
          acc <= acc + sq_ext;
          if (dcnt == DC_W'(DIM-1)) state <= INSERT;
          else dcnt <= dcnt + DC_W'(1);
        end
        INSERT: begin
          if (ins_ok) begin
            for (int i = 0; i < K; i++) begin
              vld[i] <= n_vld[i];
              dst[i] <= n_dst[i];
              lab[i] <= n_lab[i];
            end
          end
          if (int'(cnt) < K) cnt <= cnt + CNT_W'(1);
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  always_comb begin
    rd_valid = 1'b0;
    rd_dist  = '1;
    rd_label = '0;
    if (int'(rd_idx) < K) begin
      rd_valid = vld[rd_idx];
      rd_dist  = dst[rd_idx];
      rd_label = lab[rd_idx];
    end
  end

`ifdef KNN_VOTE_EN
  logic               vote_upd;
  logic [LABEL_W-1:0] vote_n;
  int                 occ;
  int                 best;

  // Strict '>' while scanning nearest-first makes the nearest tied label win.
  always_comb begin
    vote_n = '0;
    best   = 0;
    occ    = 0;
    for (int i = 0; i < K; i++) begin
      if (vld[i]) begin
        occ = 0;
        for (int j = 0; j < K; j++) begin
          if (vld[j] && (lab[j] == lab[i])) occ = occ + 1;
        end
        if (occ > best) begin
          best   = occ;
          vote_n = lab[i];
        end
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vote_upd   <= 1'b0;
      vote_label <= '0;
    end else begin
      vote_upd <= clear | (state == INSERT);
      if (vote_upd) vote_label <= vote_n;
    end
  end
`endif

endmodule

// File: tb/tb_knn_topk_core.sv
// Directed plus randomized bench for knn_topk_core against a queue-based model.
module tb_knn_topk_core;
  localparam int DATA_W  = 16;
  localparam int DIM     = 2;
  localparam int K       = 4;
  localparam int LABEL_W = 8;
  localparam logic [63:0] ONES = 64'h3_FFFF_FFFF;

  logic        clk = 1'b0;
  logic        rst;
  logic        clear;
  logic [31:0] test_pt;
  logic        tr_valid;
  logic        tr_ready;
  logic [31:0] tr_pt;
  logic [7:0]  tr_label;
  logic        busy;
  logic [2:0]  count;
  logic [1:0]  rd_idx;
  logic        rd_valid;
  logic [33:0] rd_dist;
  logic [7:0]  rd_label;
`ifdef KNN_VOTE_EN
  logic [7:0]  vote_label;
`endif

  always #5 clk = ~clk;

  knn_topk_core #(
    .DATA_W(DATA_W), .DIM(DIM), .K(K), .LABEL_W(LABEL_W)
  ) dut (
    .clk(clk), .rst(rst), .clear(clear),
    .test_pt(test_pt), .tr_valid(tr_valid),
    .tr_ready(tr_ready), .tr_pt(tr_pt),
    .tr_label(tr_label), .busy(busy),
    .count(count), .rd_idx(rd_idx),
    .rd_valid(rd_valid), .rd_dist(rd_dist),
    .rd_label(rd_label)
`ifdef KNN_VOTE_EN
    , .vote_label(vote_label)
`endif
  );

  int vectors = 0;
  int miscompares = 0;
  longint mdist[$];
  int     mlab[$];
  int     tx, ty;

  task automatic chk(input string tag, input logic [63:0] obs,
                     input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] pack(input int x, input int y);
    return {y[15:0], x[15:0]};
  endfunction

  function automatic int model_vote();
    int best = 0;
    int v = 0;
    for (int i = 0; i < mlab.size(); i++) begin
      int c = 0;
      foreach (mlab[j]) if (mlab[j] == mlab[i]) c++;
      if (c > best) begin
        best = c;
        v = mlab[i];
      end
    end
    return v;
  endfunction

  task automatic model_insert(input int x, input int y, input int l);
    longint dx = longint'(x) - longint'(tx);
    longint dy = longint'(y) - longint'(ty);
    longint d = dx*dx + dy*dy;
    int p = 0;
    while (p < mdist.size() && mdist[p] <= d) p++;
    if (p < K) begin
      mdist.insert(p, d);
      mlab.insert(p, l);
      if (mdist.size() > K) begin
        mdist = mdist[0:K-1];
        mlab = mlab[0:K-1];
      end
    end
  endtask

  task automatic check_list();
    @(negedge clk);
    chk("count", count, mdist.size());
    for (int i = 0; i < K; i++) begin
      rd_idx = i[1:0];
      #1;
      if (i < mdist.size()) begin
        chk("rd_valid", rd_valid, 1);
        chk("rd_dist", rd_dist, mdist[i]);
        chk("rd_label", rd_label, mlab[i]);
      end else begin
        chk("rd_valid_empty", rd_valid, 0);
        chk("rd_dist_empty", rd_dist, ONES);
        chk("rd_label_empty", rd_label, 0);
      end
    end
`ifdef KNN_VOTE_EN
    chk("vote", vote_label, model_vote());
`endif
  endtask

  task automatic set_test(input int x, input int y);
    tx = x;
    ty = y;
    test_pt = pack(x, y);
  endtask

  task automatic send(input int x, input int y, input int l);
    @(negedge clk);
    chk("ready_idle", tr_ready, 1);
    tr_pt = pack(x, y);
    tr_label = l[7:0];
    tr_valid = 1'b1;
    @(posedge clk);
    #1;
    tr_valid = 1'b0;
    tr_pt = $urandom;
    tr_label = 8'($urandom);
    test_pt = $urandom;
    for (int i = 0; i <= DIM; i++) begin
      @(negedge clk);
      chk("ready_low", tr_ready, 0);
      chk("busy_high", busy, 1);
    end
    @(negedge clk);
    chk("ready_back", tr_ready, 1);
    chk("busy_low", busy, 0);
    model_insert(x, y, l);
    test_pt = pack(tx, ty);
  endtask

  task automatic do_clear();
    @(negedge clk);
    clear = 1'b1;
    #1;
    chk("ready_clear", tr_ready, 0);
    @(posedge clk);
    #1;
    clear = 1'b0;
    mdist.delete();
    mlab.delete();
    check_list();
  endtask

  initial begin
    rst = 1'b1;
    clear = 1'b0;
    tr_valid = 1'b0;
    test_pt = '0;
    tr_pt = '0;
    tr_label = '0;
    rd_idx = '0;
    tx = 0;
    ty = 0;
    repeat (2) @(posedge clk);
    #1;
    chk("reset_ready", tr_ready, 1);
    chk("reset_busy", busy, 0);
    @(negedge clk);
    rst = 1'b0;
    check_list();

    set_test(0, 0);
    send(3, 4, 1);
    check_list();

    do_clear();
    send(1, 1, 2);
    send(5, 0, 3);
    send(2, 2, 4);
    send(0, 1, 5);
    send(10, 10, 6);
    check_list();

    do_clear();
    send(3, 4, 1);
    send(4, 3, 7);
    check_list();

    set_test(-32768, -32768);
    do_clear();
    send(32767, 32767, 9);
    check_list();
    rd_idx = 2'd0;
    #1;
    chk("extreme_dist", rd_dist, 64'd8589672450);

    set_test(0, 0);
    do_clear();
    send(1, 1, 2);
    @(negedge clk);
    tr_pt = pack(2, 0);
    tr_label = 8'd3;
    tr_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    clear = 1'b1;
    @(posedge clk);
    #1;
    clear = 1'b0;
    tr_valid = 1'b0;
    mdist.delete();
    mlab.delete();
    @(negedge clk);
    chk("clr_count", count, 0);
    chk("clr_ready", tr_ready, 1);
    chk("clr_busy", busy, 0);
    repeat (DIM + 2) @(negedge clk);
    check_list();

    @(negedge clk);
    tr_pt = pack(1, 0);
    tr_valid = 1'b1;
    clear = 1'b1;
    @(posedge clk);
    #1;
    clear = 1'b0;
    tr_valid = 1'b0;
    @(negedge clk);
    chk("clr_prio_busy", busy, 0);
    check_list();

    send(2, 0, 3);
    check_list();
    @(negedge clk);
    tr_pt = pack(1, 0);
    tr_label = 8'd4;
    tr_valid = 1'b1;
    @(posedge clk);
    #1;
    tr_valid = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    rd_idx = 2'd0;
    #1;
    chk("rst_count", count, 0);
    chk("rst_busy", busy, 0);
    chk("rst_ready", tr_ready, 1);
    chk("rst_valid", rd_valid, 0);
    @(negedge clk);
    rst = 1'b0;
    mdist.delete();
    mlab.delete();
    repeat (DIM + 2) @(negedge clk);
    check_list();

    send(1, 0, 5);
    send(2, 0, 2);
    send(3, 0, 5);
    send(4, 0, 1);
    check_list();
`ifdef KNN_VOTE_EN
    chk("vote_5", vote_label, 5);
`endif
    do_clear();
    send(1, 0, 2);
    send(2, 0, 5);
    send(3, 0, 5);
    send(4, 0, 2);
    check_list();
`ifdef KNN_VOTE_EN
    chk("vote_2", vote_label, 2);
`endif

    for (int r = 0; r < 3; r++) begin
      set_test(int'($urandom_range(0, 16)) - 8, int'($urandom_range(0, 16)) - 8);
      do_clear();
      for (int n = 0; n < 12; n++) begin
        send(tx + int'($urandom_range(0, 12)) - 6,
             ty + int'($urandom_range(0, 12)) - 6,
             int'($urandom_range(0, 3)));
        check_list();
      end
    end

    begin
      logic [15:0] r0, r1;
      r0 = 16'($urandom);
      r1 = 16'($urandom);
      set_test(int'($signed(r0)), int'($signed(r1)));
      do_clear();
      for (int n = 0; n < 8; n++) begin
        r0 = 16'($urandom);
        r1 = 16'($urandom);
        send(int'($signed(r0)), int'($signed(r1)), int'($urandom_range(0, 255)));
        check_list();
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
